// File: rtl/stripe_tile_drawer_if.sv
// Pixel-plot bus between a tile draw requester and the stripe tile drawer.
// master: requester side (start/x_base/y_base/colour/orient, sink hold),
//         observes pixel stream and status.
// slave : drawer side, accepts the request and produces the pixel stream
//         (x_out/y_out/colour_out/plot) plus busy/done status.
interface stripe_tile_drawer_if #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
);
    logic                start;
    logic [X_W-1:0]      x_base;
    logic [Y_W-1:0]      y_base;
    logic [COLOUR_W-1:0] colour;
    logic                orient;
    logic                hold;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [COLOUR_W-1:0] colour_out;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, x_base, y_base, colour, orient, hold,
        input  x_out, y_out, colour_out, plot, busy, done
    );

    modport slave (
        input  start, x_base, y_base, colour, orient, hold,
        output x_out, y_out, colour_out, plot, busy, done
    );
endinterface

// File: rtl/stripe_tile_drawer.sv
// Stripe-pattern tile renderer for the VGA plot path.
// On an accepted start it emits one pixel per cycle: NUM_LINES parallel
// lines of LINE_LEN pixels, line spacing COL_STRIDE, offset from the
// captured tile origin. orient=0 draws vertical lines, orient=1 horizontal.
// Ports:
//   clk    - clock
//   resetn - synchronous active-low reset
//   bus    - slave side of stripe_tile_drawer_if: start/x_base/y_base/
//            colour/orient request, hold stall, registered pixel outputs
//            x_out/y_out/colour_out with plot strobe, busy and done status.
module stripe_tile_drawer #(
    parameter int X_W        = 8,
    parameter int Y_W        = 7,
    parameter int COLOUR_W   = 3,
    parameter int NUM_LINES  = 8,
    parameter int LINE_LEN   = 15,
    parameter int FIRST_COL  = 8,
    parameter int COL_STRIDE = 2,
    parameter int ROW_OFFSET = 7
) (
    input logic                 clk,
    input logic                 resetn,
    stripe_tile_drawer_if.slave bus
);
    localparam int LI_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int PI_W = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam logic [LI_W-1:0] LI_LAST = LI_W'(NUM_LINES - 1);
    localparam logic [PI_W-1:0] PI_LAST = PI_W'(LINE_LEN - 1);

    typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

    state_t              state, stateNext;
    logic [LI_W-1:0]     li, liNext;
    logic [PI_W-1:0]     pi, piNext;
    logic [X_W-1:0]      xb, xbNext;
    logic [Y_W-1:0]      yb, ybNext;
    logic [COLOUR_W-1:0] col, colNext;
    logic                ori, oriNext;
    logic [X_W-1:0]      xOut, xOutNext;
    logic [Y_W-1:0]      yOut, yOutNext;
    logic [COLOUR_W-1:0] colOut, colOutNext;
    logic                plot, plotNext;
    logic                busy, busyNext;
    logic                done, doneNext;

    logic [X_W-1:0]      acrossX, alongX, pixX;
    logic [Y_W-1:0]      acrossY, alongY, pixY;
    logic                lastPix;

    assign lastPix = (li == LI_LAST) && (pi == PI_LAST);

    // Offsets are computed at full integer width and truncated, so the
    // coordinate sums wrap silently at the output width.
    always_comb begin
        acrossX = X_W'(FIRST_COL + 32'(li) * COL_STRIDE);
        acrossY = Y_W'(FIRST_COL + 32'(li) * COL_STRIDE);
        alongX  = X_W'(ROW_OFFSET + 32'(pi));
        alongY  = Y_W'(ROW_OFFSET + 32'(pi));
        if (ori) begin
            pixX = xb + alongX;
            pixY = yb + acrossY;
        end else begin
            pixX = xb + acrossX;
            pixY = yb + alongY;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            li     <= '0;
            pi     <= '0;
            xb     <= '0;
            yb     <= '0;
            col    <= '0;
            ori    <= 1'b0;
            xOut   <= '0;
            yOut   <= '0;
            colOut <= '0;
            plot   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= stateNext;
            li     <= liNext;
            pi     <= piNext;
            xb     <= xbNext;
            yb     <= ybNext;
            col    <= colNext;
            ori    <= oriNext;
            xOut   <= xOutNext;
            yOut   <= yOutNext;
            colOut <= colOutNext;
            plot   <= plotNext;
            busy   <= busyNext;
            done   <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = DRAW;
            DRAW:    if (!bus.hold && lastPix) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        liNext     = li;
        piNext     = pi;
        xbNext     = xb;
        ybNext     = yb;
        colNext    = col;
        oriNext    = ori;
        xOutNext   = xOut;
        yOutNext   = yOut;
        colOutNext = colOut;
        plotNext   = 1'b0;
        doneNext   = (state == FIN);
        // busy is registered from the next state so it covers DRAW and FIN only.
        busyNext   = (stateNext != IDLE);
        case (state)
            IDLE: begin
                if (bus.start) begin
                    xbNext  = bus.x_base;
                    ybNext  = bus.y_base;
                    colNext = bus.colour;
                    oriNext = bus.orient;
                    liNext  = '0;
                    piNext  = '0;
                end
            end
            DRAW: begin
                if (!bus.hold) begin
                    xOutNext   = pixX;
                    yOutNext   = pixY;
                    colOutNext = col;
                    plotNext   = 1'b1;
                    if (pi == PI_LAST) begin
                        piNext = '0;
                        liNext = li + 1'b1;
                    end else begin
                        piNext = pi + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.x_out      = xOut;
    assign bus.y_out      = yOut;
    assign bus.colour_out = colOut;
    assign bus.plot       = plot;
    assign bus.busy       = busy;
    assign bus.done       = done;
endmodule
